// File: rtl/ladybird_aclint.sv
// ladybird_aclint: MSWI/MTIMER/SSWI responder with a 64-bit mtime and one outstanding bus response
module ladybird_aclint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TIMER_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        msip,
  output logic        mtip,
  output logic        ssip_set
);
  localparam int PW = TIMER_DIV > 1 ? $clog2(TIMER_DIV) : 1;
  typedef enum logic {IDLE, RESP} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic msip_q, msip_d, mtip_q, mtip_d, ssip_q, ssip_d;
  logic [31:0] rsp_data_q, rsp_data_d, rdata, off_full;
  logic [15:0] off;
  logic accept, wr, tick, unused_off;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
  assign req_ready = (state_q == IDLE) | rsp_ready;
  assign rsp_valid = state_q == RESP;
  assign rsp_data = rsp_data_q;
  assign msip = msip_q;
  assign mtip = mtip_q;
  assign ssip_set = ssip_q;
  assign off_full = req_addr - BASE_ADDR;
  assign off = {off_full[15:2], 2'b00};
  assign unused_off = ^{off_full[31:16], off_full[1:0]};
  always_comb begin
    accept = req_valid & req_ready;
    wr = |req_wstrb;
    tick = presc_q == PW'(TIMER_DIV - 1);
    presc_d = tick ? '0 : presc_q + PW'(1);
    rdata = off == 16'h0000 ? {31'd0, msip_q}
          : off == 16'h4000 ? mtimecmp_q[31:0]
          : off == 16'h4004 ? mtimecmp_q[63:32]
          : off == 16'hBFF8 ? mtime_q[31:0]
          : off == 16'hBFFC ? mtime_q[63:32] : 32'd0;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d = msip_q;
    // a write to either mtime word replaces the tick; the untouched word sees no carry
    if (accept && wr) begin
      mtime_d = off == 16'hBFF8 ? {mtime_q[63:32], merge(mtime_q[31:0], req_wdata, req_wstrb)}
              : off == 16'hBFFC ? {merge(mtime_q[63:32], req_wdata, req_wstrb), mtime_q[31:0]} : mtime_d;
      mtimecmp_d = off == 16'h4000 ? {mtimecmp_q[63:32], merge(mtimecmp_q[31:0], req_wdata, req_wstrb)}
                 : off == 16'h4004 ? {merge(mtimecmp_q[63:32], req_wdata, req_wstrb), mtimecmp_q[31:0]} : mtimecmp_q;
      msip_d = (off == 16'h0000 && req_wstrb[0]) ? req_wdata[0] : msip_q;
    end
    ssip_d = accept & wr & (off == 16'h8000) & req_wstrb[0] & req_wdata[0];
    mtip_d = mtime_q >= mtimecmp_q;
    state_d = accept ? RESP : rsp_ready ? IDLE : state_q;
    rsp_data_d = accept ? (wr ? 32'd0 : rdata) : rsp_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      mtime_q <= '0;
      mtimecmp_q <= '1;
      msip_q <= 1'b0;
      mtip_q <= 1'b0;
      ssip_q <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q <= msip_d;
      mtip_q <= mtip_d;
      ssip_q <= ssip_d;
      rsp_data_q <= rsp_data_d;
    end
  end
endmodule
